// File: rtl/note_sequencer.sv
// Melody player: walks a writable note table and drives the tone divider
// and LCD text for each entry, holding every note for its tick count.
module note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     tone_en,
    output logic [31:0]              div,
    output logic [31:0]              lcd_ch,
    output logic [$clog2(DEPTH)-1:0] note_idx
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [7:0]      GAP_INIT = 8'(GAP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PLAY, S_GAP, S_ADV, S_END
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      gcnt_q, gcnt_d;
    logic [7:0]      note_tab_q [DEPTH];
    logic [7:0]      cur_entry;
    logic [31:0]     div_q, div_d, lcd_q, lcd_d;
    logic            tone_q, tone_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [31:0] note_div(input logic [2:0] code);
        case (code)
            3'd0:    return 32'd95602;
            3'd1:    return 32'd85179;
            3'd2:    return 32'd75873;
            3'd3:    return 32'd71633;
            3'd4:    return 32'd63857;
            3'd5:    return 32'd56818;
            3'd6:    return 32'd50659;
            default: return 32'd47801;
        endcase
    endfunction

    function automatic logic [31:0] note_lcd(input logic [2:0] code);
        case (code)
            3'd0:    return 32'h446F2020;
            3'd1:    return 32'h52652020;
            3'd2:    return 32'h4D692020;
            3'd3:    return 32'h46612020;
            3'd4:    return 32'h536F2020;
            3'd5:    return 32'h4C612020;
            3'd6:    return 32'h53692020;
            default: return 32'h446F3220;
        endcase
    endfunction

    assign cur_entry = note_tab_q[idx_q];

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            div_q   <= 32'd1;
            lcd_q   <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                note_tab_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            div_q   <= div_d;
            lcd_q   <= lcd_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            // The table is only writable while idle so a playing melody never changes under us.
            if (wr_en && state_q == S_IDLE) begin
                note_tab_q[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start && !stop) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
                S_FETCH: begin
                    if (cur_entry[3:0] == 4'd0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_PLAY;
                        cnt_d   = cur_entry[3:0];
                    end
                end
                S_PLAY: if (tick) begin
                    if (cnt_q == 4'd1) begin
                        cnt_d = '0;
                        if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                            gcnt_d  = GAP_INIT;
                        end else begin
                            state_d = S_ADV;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_GAP: if (tick) begin
                    if (gcnt_q == 8'd1) begin
                        state_d = S_ADV;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q - 8'd1;
                    end
                end
                S_ADV: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_FETCH;
                        idx_d   = idx_q + AW'(1);
                    end
                end
                S_END: begin
                    idx_d   = '0;
                    state_d = loop_en ? S_FETCH : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        div_d  = div_q;
        lcd_d  = lcd_q;
        tone_d = tone_q;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_END) && !loop_en && !stop;
        // Outputs hold through ADV/FETCH so back-to-back notes without a gap do not click.
        if (state_d == S_IDLE || state_d == S_GAP || state_d == S_END) begin
            div_d  = 32'd1;
            lcd_d  = '0;
            tone_d = 1'b0;
        end else if (state_q == S_FETCH && state_d == S_PLAY) begin
            if (cur_entry[7]) begin
                div_d  = 32'd1;
                lcd_d  = '0;
                tone_d = 1'b0;
            end else begin
                div_d  = note_div(cur_entry[6:4]);
                lcd_d  = note_lcd(cur_entry[6:4]);
                tone_d = 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign tone_en  = tone_q;
    assign div      = div_q;
    assign lcd_ch   = lcd_q;
    assign note_idx = idx_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed from the note table.
module tb_note_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        busy, done, tone_en;
    logic [31:0] div, lcd_ch;
    logic [3:0]  note_idx;

    int total_cnt = 0;
    int pass_cnt  = 0;

    note_sequencer #(.DEPTH(16), .GAP_TICKS(1)) dut (
        .clock_in (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .tone_en  (tone_en),
        .div      (div),
        .lcd_ch   (lcd_ch),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic stepn(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic tick1();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        step();
    endtask

    initial begin
        // Reset values while reset is held
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div", div, 1);
        check("rst_lcd", lcd_ch, 0);
        check("rst_tone", tone_en, 0);
        check("rst_idx", note_idx, 0);
        reset = 1'b0;
        step();

        // Empty table: busy for FETCH and END only, done as busy falls
        pulse_start();
        check("empty_busy1", busy, 1);
        step();
        check("empty_busy2", busy, 1);
        check("empty_div", div, 1);
        step();
        check("empty_busy_fall", busy, 0);
        check("empty_done", done, 1);
        step();
        check("empty_done_clr", done, 0);

        // Two-note melody with gap
        do_reset();
        wr(4'd0, 8'h02); wr(4'd1, 8'h13); wr(4'd2, 8'h00);
        loop_en = 1'b0;
        pulse_start();
        check("m_busy_fetch", busy, 1);
        check("m_div_fetch", div, 1);
        step();
        check("m_div_do", div, 95602);
        check("m_lcd_do", lcd_ch, 32'h446F2020);
        check("m_tone_do", tone_en, 1);
        tick1(); stepn(3);
        check("m_div_do_hold", div, 95602);
        tick1();
        check("m_gap1_div", div, 1);
        check("m_gap1_tone", tone_en, 0);
        tick1(); step(); step();
        check("m_div_re", div, 85179);
        check("m_idx_re", note_idx, 1);
        tick1(); tick1();
        check("m_div_re_hold", div, 85179);
        tick1();
        check("m_gap2_div", div, 1);
        tick1();
        check("m_busy_adv", busy, 1);
        step(); step();
        check("m_busy_end", busy, 1);
        check("m_done_early", done, 0);
        step();
        check("m_busy_fall", busy, 0);
        check("m_done", done, 1);
        step();
        check("m_done_once", done, 0);

        // Full table of Do2, looping once, then ending with done
        do_reset();
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h71);
        loop_en = 1'b1;
        pulse_start();
        step();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) loop_en = 1'b0;
            for (int i = 0; i < 16; i++) begin
                check($sformatf("loop_idx_p%0d_%0d", pass, i), note_idx, 32'(i));
                check($sformatf("loop_lcd_p%0d_%0d", pass, i), lcd_ch, 32'h446F3220);
                tick1(); tick1();
                if (i < 15) begin
                    step(); step();
                end else if (pass == 0) begin
                    step(); step();
                    check("loop_no_done", done, 0);
                    check("loop_busy", busy, 1);
                    step();
                end else begin
                    step(); step();
                    check("loop_end_done", done, 1);
                    check("loop_end_busy", busy, 0);
                end
            end
        end

        // Rest followed by Si
        do_reset();
        wr(4'd0, 8'h82); wr(4'd1, 8'h61);
        pulse_start();
        step();
        check("rest_tone", tone_en, 0);
        check("rest_div", div, 1);
        check("rest_lcd", lcd_ch, 0);
        check("rest_busy", busy, 1);
        tick1();
        check("rest_div_hold", div, 1);
        tick1(); tick1(); step(); step();
        check("si_div", div, 50659);
        check("si_lcd", lcd_ch, 32'h53692020);
        check("si_tone", tone_en, 1);
        tick1();
        check("si_gap_div", div, 1);
        loop_en = 1'b0;
        tick1(); stepn(3);
        check("si_done", done, 1);

        // Stop+start during PLAY, write during PLAY ignored
        do_reset();
        wr(4'd0, 8'h03);
        pulse_start();
        step();
        check("sp_div", div, 95602);
        wr(4'd0, 8'h45);
        check("sp_busy_after_wr", busy, 1);
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("sp_busy", busy, 0);
        check("sp_div_silent", div, 1);
        check("sp_tone", tone_en, 0);
        check("sp_lcd", lcd_ch, 0);
        check("sp_done", done, 0);
        check("sp_idx", note_idx, 0);
        step();
        check("sp_done_later", done, 0);
        check("sp_stay_idle", busy, 0);
        pulse_start();
        step();
        check("sp_table_kept_div", div, 95602);
        check("sp_table_kept_lcd", lcd_ch, 32'h446F2020);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Asynchronous reset mid-note
        do_reset();
        wr(4'd0, 8'h05);
        pulse_start();
        step();
        check("ar_div_pre", div, 95602);
        #2 reset = 1'b1;
        #1;
        check("ar_div", div, 1);
        check("ar_busy", busy, 0);
        check("ar_tone", tone_en, 0);
        check("ar_lcd", lcd_ch, 0);
        #1 reset = 1'b0;
        step();
        pulse_start();
        check("ar_busy1", busy, 1);
        step();
        check("ar_busy2", busy, 1);
        check("ar_div_empty", div, 1);
        step();
        check("ar_busy_fall", busy, 0);
        check("ar_done", done, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
